// File: rtl/reg_file_2r1w_pkg.sv
// reg_file_2r1w_pkg: shared default sizes and address-width helper for the register file
package reg_file_2r1w_pkg;
  localparam int DefWidth = 32;
  localparam int DefDepth = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/reg_file_2r1w_mux_nto1.sv
// mux_nto1: combinational N-to-1 word select used by each read port
module mux_nto1
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH = DefWidth,
  parameter int N = DefDepth,
  localparam int SW = clog2(N)
) (
  input  logic [N-1:0][WIDTH-1:0] din,
  input  logic [SW-1:0]           sel,
  output logic [WIDTH-1:0]        dout
);
  assign dout = din[sel];
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: one write port, two registered read ports with write-first bypass and optional zero register
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH = DefWidth,
  parameter int DEPTH = DefDepth,
  parameter int ZERO_REG = 0,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en0,
  input  logic [AW-1:0]    rd_addr0,
  output logic [WIDTH-1:0] rd_data0,
  output logic             rd_valid0,
  input  logic             rd_en1,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  output logic             rd_valid1
);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic             rdEn    [2];
  logic [AW-1:0]    rdAddr  [2];
  logic [WIDTH-1:0] rdData  [2];
  logic             rdValid [2];
  assign rdEn[0] = rd_en0;
  assign rdEn[1] = rd_en1;
  assign rdAddr[0] = rd_addr0;
  assign rdAddr[1] = rd_addr1;
  assign rd_data0 = rdData[0];
  assign rd_data1 = rdData[1];
  assign rd_valid0 = rdValid[0];
  assign rd_valid1 = rdValid[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs <= '0;
    else if (wr_en && !(ZERO_REG != 0 && wr_addr == '0)) regs[wr_addr] <= wr_data;
  end
  for (genvar p = 0; p < 2; p++) begin : gPort
    logic [WIDTH-1:0] muxOut;
    logic [WIDTH-1:0] selData;
    mux_nto1 #(.WIDTH(WIDTH), .N(DEPTH)) uMux (
      .din (regs),
      .sel (rdAddr[p]),
      .dout(muxOut)
    );
    // zero register outranks the bypass so a dropped write to r0 never leaks through
    always_comb selData = (ZERO_REG != 0 && rdAddr[p] == '0) ? '0 :
                          (wr_en && wr_addr == rdAddr[p]) ? wr_data : muxOut;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdData[p] <= '0;
        rdValid[p] <= 1'b0;
      end else begin
        rdValid[p] <= rdEn[p];
        if (rdEn[p]) rdData[p] <= selData;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed stimulus with scoreboard queues checked by a negedge monitor
module tb_reg_file_2r1w;
  logic clk, rst_n;
  logic aWrEn, aRdEn0, aRdEn1, aRdValid0, aRdValid1;
  logic [1:0] aWrAddr, aRdAddr0, aRdAddr1;
  logic [31:0] aWrData, aRdData0, aRdData1;
  logic zWrEn, zRdEn0, zRdEn1, zRdValid0, zRdValid1;
  logic [1:0] zWrAddr, zRdAddr0, zRdAddr1;
  logic [31:0] zWrData, zRdData0, zRdData1;
  logic pWrEn, pRdEn0, pRdEn1, pRdValid0, pRdValid1;
  logic [4:0] pWrAddr, pRdAddr0, pRdAddr1;
  logic [7:0] pWrData, pRdData0, pRdData1;
  logic [31:0] qA0[$], qA1[$], qZ0[$], qZ1[$], qP0[$], qP1[$];
  int total = 0;
  int passed = 0;

  reg_file_2r1w dutA (
    .clk(clk), .rst_n(rst_n), .wr_en(aWrEn), .wr_addr(aWrAddr), .wr_data(aWrData),
    .rd_en0(aRdEn0), .rd_addr0(aRdAddr0), .rd_data0(aRdData0), .rd_valid0(aRdValid0),
    .rd_en1(aRdEn1), .rd_addr1(aRdAddr1), .rd_data1(aRdData1), .rd_valid1(aRdValid1)
  );
  reg_file_2r1w #(.ZERO_REG(1)) dutZ (
    .clk(clk), .rst_n(rst_n), .wr_en(zWrEn), .wr_addr(zWrAddr), .wr_data(zWrData),
    .rd_en0(zRdEn0), .rd_addr0(zRdAddr0), .rd_data0(zRdData0), .rd_valid0(zRdValid0),
    .rd_en1(zRdEn1), .rd_addr1(zRdAddr1), .rd_data1(zRdData1), .rd_valid1(zRdValid1)
  );
  reg_file_2r1w #(.WIDTH(8), .DEPTH(32)) dutP (
    .clk(clk), .rst_n(rst_n), .wr_en(pWrEn), .wr_addr(pWrAddr), .wr_data(pWrData),
    .rd_en0(pRdEn0), .rd_addr0(pRdAddr0), .rd_data0(pRdData0), .rd_valid0(pRdValid0),
    .rd_en1(pRdEn1), .rd_addr1(pRdAddr1), .rd_data1(pRdData1), .rd_valid1(pRdValid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic unexpected(input string name);
    total++;
    $display("FAIL %s: valid seen with no read outstanding", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic opA(input bit we, input logic [1:0] wa, input logic [31:0] wd,
                     input bit r0, input logic [1:0] a0, input logic [31:0] e0,
                     input bit r1, input logic [1:0] a1, input logic [31:0] e1);
    aWrEn = we; aWrAddr = wa; aWrData = wd;
    aRdEn0 = r0; aRdAddr0 = a0; aRdEn1 = r1; aRdAddr1 = a1;
    if (r0) qA0.push_back(e0);
    if (r1) qA1.push_back(e1);
    tick();
  endtask

  task automatic opZ(input bit we, input logic [1:0] wa, input logic [31:0] wd,
                     input bit r0, input logic [1:0] a0, input logic [31:0] e0,
                     input bit r1, input logic [1:0] a1, input logic [31:0] e1);
    zWrEn = we; zWrAddr = wa; zWrData = wd;
    zRdEn0 = r0; zRdAddr0 = a0; zRdEn1 = r1; zRdAddr1 = a1;
    if (r0) qZ0.push_back(e0);
    if (r1) qZ1.push_back(e1);
    tick();
  endtask

  task automatic opP(input bit we, input logic [4:0] wa, input logic [7:0] wd,
                     input bit r0, input logic [4:0] a0, input logic [7:0] e0,
                     input bit r1, input logic [4:0] a1, input logic [7:0] e1);
    pWrEn = we; pWrAddr = wa; pWrData = wd;
    pRdEn0 = r0; pRdAddr0 = a0; pRdEn1 = r1; pRdAddr1 = a1;
    if (r0) qP0.push_back({24'h0, e0});
    if (r1) qP1.push_back({24'h0, e1});
    tick();
  endtask

  always @(negedge clk) begin
    if (aRdValid0) begin
      if (qA0.size() == 0) unexpected("A port0");
      else chk("A port0 data", aRdData0, qA0.pop_front());
    end
    if (aRdValid1) begin
      if (qA1.size() == 0) unexpected("A port1");
      else chk("A port1 data", aRdData1, qA1.pop_front());
    end
    if (zRdValid0) begin
      if (qZ0.size() == 0) unexpected("Z port0");
      else chk("Z port0 data", zRdData0, qZ0.pop_front());
    end
    if (zRdValid1) begin
      if (qZ1.size() == 0) unexpected("Z port1");
      else chk("Z port1 data", zRdData1, qZ1.pop_front());
    end
    if (pRdValid0) begin
      if (qP0.size() == 0) unexpected("P port0");
      else chk("P port0 data", {24'h0, pRdData0}, qP0.pop_front());
    end
    if (pRdValid1) begin
      if (qP1.size() == 0) unexpected("P port1");
      else chk("P port1 data", {24'h0, pRdData1}, qP1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    {aWrEn, aRdEn0, aRdEn1, aWrAddr, aRdAddr0, aRdAddr1, aWrData} = '0;
    {zWrEn, zRdEn0, zRdEn1, zWrAddr, zRdAddr0, zRdAddr1, zWrData} = '0;
    {pWrEn, pRdEn0, pRdEn1, pWrAddr, pRdAddr0, pRdAddr1, pWrData} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("reset rd_data0", aRdData0, 0);
    chk("reset rd_valid0", 32'(aRdValid0), 0);
    chk("reset rd_data1", aRdData1, 0);
    chk("reset rd_valid1", 32'(aRdValid1), 0);
    // basic write/read, bypass, hold
    opA(1, 0, 'h11111111, 0, 0, 0, 0, 0, 0);
    opA(1, 1, 'h22222222, 0, 0, 0, 0, 0, 0);
    opA(1, 2, 'h33333333, 0, 0, 0, 0, 0, 0);
    opA(1, 3, 'h44444444, 0, 0, 0, 0, 0, 0);
    opA(1, 1, 'hAAAA0000, 1, 3, 'h44444444, 1, 0, 'h11111111);
    opA(1, 1, 'h12345678, 1, 1, 'h12345678, 1, 1, 'h12345678);
    opA(0, 0, 0, 1, 2, 'h33333333, 1, 1, 'h12345678);
    for (int i = 0; i < 3; i++) begin
      opA(i == 0, 2, 'h99, 0, 0, 0, 0, 0, 0);
      chk("hold rd_data0", aRdData0, 'h33333333);
      chk("hold rd_valid0", 32'(aRdValid0), 0);
    end
    opA(0, 0, 0, 1, 2, 'h99, 0, 0, 0);
    // mid-cycle async reset with a read pending
    opA(1, 2, 'hDEADBEEF, 1, 2, 'hDEADBEEF, 0, 0, 0);
    aWrEn = 1'b0;
    aRdEn0 = 1'b1; aRdAddr0 = 2;
    aRdEn1 = 1'b1; aRdAddr1 = 2;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset rd_data0", aRdData0, 0);
    chk("async reset rd_valid0", 32'(aRdValid0), 0);
    chk("async reset rd_data1", aRdData1, 0);
    chk("async reset rd_valid1", 32'(aRdValid1), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    aRdEn0 = 1'b0;
    aRdEn1 = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("no valid after reset port0", 32'(aRdValid0), 0);
    chk("no valid after reset port1", 32'(aRdValid1), 0);
    opA(0, 0, 0, 1, 2, 0, 1, 2, 0);
    opA(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // zero register
    opZ(1, 0, 'hFFFFFFFF, 1, 0, 0, 1, 0, 0);
    opZ(1, 1, 'h00005555, 1, 0, 0, 1, 1, 'h00005555);
    opZ(0, 0, 0, 1, 0, 0, 1, 0, 0);
    opZ(0, 0, 0, 1, 1, 'h00005555, 0, 0, 0);
    opZ(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // 32 x 8 streaming
    for (int i = 0; i < 32; i++) opP(1, i[4:0], 8'(i), 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      opP(0, 0, 0, 1, i[4:0], 8'(i), 1, 5'(31 - i), 8'(31 - i));
      if (i > 0) chk("P stream valid0", 32'(pRdValid0), 1);
      if (i > 0) chk("P stream valid1", 32'(pRdValid1), 1);
    end
    opP(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("A0 queue drained", qA0.size(), 0);
    chk("A1 queue drained", qA1.size(), 0);
    chk("Z0 queue drained", qZ0.size(), 0);
    chk("Z1 queue drained", qZ1.size(), 0);
    chk("P0 queue drained", qP0.size(), 0);
    chk("P1 queue drained", qP1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
